// File: rtl/hazard_unit.sv
// Hazard controller: operand forwarding, load-use stall, branch flush,
// and saturating stall/flush event counters for the 5-stage pipeline.
module hazard_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           RdEO,
  input  logic                 RegWriteE,
  input  logic [1:0]           ResultSrcE,
  input  logic                 PCSrcE,
  output logic                 enableStallF,
  output logic                 enableStallD,
  output logic                 flushD,
  output logic                 resetFlushE,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [4:0]           rs1e_q, rs1e_d;
  logic [4:0]           rs2e_q, rs2e_d;
  logic [4:0]           rdm_q, rdm_d;
  logic [4:0]           rdw_q, rdw_d;
  logic                 regwm_q, regwm_d;
  logic                 regww_q, regww_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                 lw_stall;

  // M-stage match wins over W; x0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rdm,
    input logic       regwm,
    input logic [4:0] rdw,
    input logic       regww
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != 5'd0 && rs == rdm && regwm)
      sel = 2'b10;
    else if (rs != 5'd0 && rs == rdw && regww)
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    lw_stall = (ResultSrcE == 2'b01) && (RdEO != 5'd0)
               && (Rs1D == RdEO || Rs2D == RdEO) && !PCSrcE;

    enableStallF = !lw_stall && !reset;
    enableStallD = !lw_stall && !reset;
    flushD       = PCSrcE || reset;
    resetFlushE  = lw_stall || PCSrcE || reset;

    ForwardAE = fwd_sel(rs1e_q, rdm_q, regwm_q, rdw_q, regww_q);
    ForwardBE = fwd_sel(rs2e_q, rdm_q, regwm_q, rdw_q, regww_q);

    rdm_d   = RdEO;
    regwm_d = RegWriteE;
    rdw_d   = rdm_q;
    regww_d = regwm_q;
    rs1e_d  = resetFlushE ? 5'd0 : Rs1D;
    rs2e_d  = resetFlushE ? 5'd0 : Rs2D;

    stall_cnt_d = stall_cnt_q;
    if (lw_stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_ONE;

    flush_cnt_d = flush_cnt_q;
    if (PCSrcE && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs1e_q      <= 5'd0;
      rs2e_q      <= 5'd0;
      rdm_q       <= 5'd0;
      rdw_q       <= 5'd0;
      regwm_q     <= 1'b0;
      regww_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      rs1e_q      <= rs1e_d;
      rs2e_q      <= rs2e_d;
      rdm_q       <= rdm_d;
      rdw_q       <= rdw_d;
      regwm_q     <= regwm_d;
      regww_q     <= regww_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, load-use, branch flush,
// counter saturation and reset behaviour with hand-derived expectations.
module tb_hazard_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    Rs1D, Rs2D, RdEO;
  logic          RegWriteE;
  logic [1:0]    ResultSrcE;
  logic          PCSrcE;
  logic          enableStallF, enableStallD, flushD, resetFlushE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [CW-1:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  hazard_unit #(.CNT_WIDTH(CW)) dut (
    .clk(clk),
    .reset(reset),
    .Rs1D(Rs1D),
    .Rs2D(Rs2D),
    .RdEO(RdEO),
    .RegWriteE(RegWriteE),
    .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE),
    .enableStallF(enableStallF),
    .enableStallD(enableStallD),
    .flushD(flushD),
    .resetFlushE(resetFlushE),
    .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE),
    .stall_count(stall_count),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw,
                       input logic [1:0] rsrc, input logic pc);
    Rs1D = rs1; Rs2D = rs2; RdEO = rd;
    RegWriteE = rw; ResultSrcE = rsrc; PCSrcE = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 2'b00, 0);
    tick(); tick();
    check("rst_fwdA", int'(ForwardAE), 0);
    check("rst_fwdB", int'(ForwardBE), 0);
    check("rst_enF", int'(enableStallF), 0);
    check("rst_enD", int'(enableStallD), 0);
    check("rst_flushD", int'(flushD), 1);
    check("rst_flushE", int'(resetFlushE), 1);
    check("rst_scnt", int'(stall_count), 0);
    check("rst_fcnt", int'(flush_count), 0);

    reset = 1'b0;
    drive(0, 0, 0, 0, 2'b00, 0);
    check("idle_enF", int'(enableStallF), 1);
    check("idle_flushD", int'(flushD), 0);
    check("idle_flushE", int'(resetFlushE), 0);

    // add x5 in E, dependent in D: forwards from M next cycle
    drive(5, 6, 5, 1, 2'b00, 0);
    tick();
    check("raw_m_fwdA", int'(ForwardAE), 2);
    check("raw_m_fwdB", int'(ForwardBE), 0);
    drive(0, 0, 0, 0, 2'b00, 0);
    tick();
    check("raw_gap_fwdA", int'(ForwardAE), 0);
    // dependent issued one cycle later: forwards from W
    drive(0, 0, 5, 1, 2'b00, 0);
    tick();
    drive(5, 0, 0, 0, 2'b00, 0);
    tick();
    check("raw_w_fwdA", int'(ForwardAE), 1);
    check("raw_w_fwdB", int'(ForwardBE), 0);

    // M over W: both write x7
    drive(0, 0, 7, 1, 2'b00, 0);
    tick();
    drive(0, 7, 7, 1, 2'b00, 0);
    tick();
    check("mw_fwdB", int'(ForwardBE), 2);
    check("mw_fwdA", int'(ForwardAE), 0);
    drive(0, 0, 0, 0, 2'b00, 0);
    tick();

    // x0 load never stalls, x0 never forwarded
    drive(0, 0, 0, 1, 2'b01, 0);
    check("x0_enF", int'(enableStallF), 1);
    check("x0_flushE", int'(resetFlushE), 0);
    tick();
    check("x0_fwdA", int'(ForwardAE), 0);
    check("x0_fwdB", int'(ForwardBE), 0);

    // load-use on rs2
    drive(0, 3, 3, 1, 2'b01, 0);
    check("lu_enF", int'(enableStallF), 0);
    check("lu_enD", int'(enableStallD), 0);
    check("lu_flushE", int'(resetFlushE), 1);
    check("lu_flushD", int'(flushD), 0);
    tick();
    check("lu_scnt", int'(stall_count), 1);
    check("lu_bubble_fwdB", int'(ForwardBE), 0);
    drive(0, 3, 0, 0, 2'b00, 0);
    check("lu_rel_enF", int'(enableStallF), 1);
    check("lu_rel_flushE", int'(resetFlushE), 0);
    tick();
    check("lu_fwdB", int'(ForwardBE), 1);
    check("lu_scnt2", int'(stall_count), 1);

    // taken branch masks load-use
    drive(3, 0, 3, 1, 2'b01, 1);
    check("br_flushD", int'(flushD), 1);
    check("br_flushE", int'(resetFlushE), 1);
    check("br_enF", int'(enableStallF), 1);
    check("br_enD", int'(enableStallD), 1);
    tick();
    check("br_fcnt", int'(flush_count), 1);
    check("br_scnt", int'(stall_count), 1);
    check("br_bubble_fwdA", int'(ForwardAE), 0);

    // stall counter saturation: 1 + 14 = 15, then hold
    drive(4, 0, 4, 1, 2'b01, 0);
    for (int i = 0; i < 14; i++) tick();
    check("sat_s_15", int'(stall_count), 15);
    for (int i = 0; i < 6; i++) tick();
    check("sat_s_hold", int'(stall_count), 15);

    drive(0, 0, 0, 0, 2'b00, 1);
    for (int i = 0; i < 20; i++) tick();
    check("sat_f_hold", int'(flush_count), 15);
    check("sat_f_scnt", int'(stall_count), 15);

    // build a forward, then reset mid-operation
    drive(9, 0, 9, 1, 2'b00, 0);
    tick();
    check("pre_rst_fwdA", int'(ForwardAE), 2);
    reset = 1'b1;
    #1;
    check("mid_rst_enF", int'(enableStallF), 0);
    check("mid_rst_flushD", int'(flushD), 1);
    check("mid_rst_flushE", int'(resetFlushE), 1);
    tick();
    check("mid_rst_fwdA", int'(ForwardAE), 0);
    check("mid_rst_scnt", int'(stall_count), 0);
    check("mid_rst_fcnt", int'(flush_count), 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 2'b00, 0);
    check("post_rst_fwdA", int'(ForwardAE), 0);
    check("post_rst_fwdB", int'(ForwardBE), 0);
    check("post_rst_enF", int'(enableStallF), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
